// File: rtl/wordle_score_ctrl.sv
`timescale 1ns/1ps
// wordle_score_ctrl: scores a 5-letter guess against the latched target word,
// one letter comparison per cycle. It uses Wordle duplicate-letter rules:
// exact matches are marked first, then each remaining guess letter claims at
// most one unused target letter as a yellow. The block also tracks the guess
// count and the win/lose status for the current game.
module wordle_score_ctrl #(
  parameter int unsigned LETTER_W    = 8,
  parameter int unsigned WORD_LEN    = 5,
  parameter int unsigned MAX_GUESSES = 6
) (
  input  logic                         Clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [LETTER_W*WORD_LEN-1:0] target_word,
  input  logic                         guess_valid,
  input  logic [LETTER_W*WORD_LEN-1:0] guess_word,
  output logic                         guess_ready,
  output logic                         busy,
  output logic                         result_valid,
  output logic [2*WORD_LEN-1:0]        result,
  output logic [2:0]                   guess_idx,
  output logic                         win,
  output logic                         lose,
  output logic                         game_over
);

  localparam int unsigned IDX_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_LEN - 1);
  localparam logic [2:0] GUESS_LIMIT = 3'(MAX_GUESSES);

  localparam logic [1:0] MARK_GRAY   = 2'b00;
  localparam logic [1:0] MARK_YELLOW = 2'b01;
  localparam logic [1:0] MARK_GREEN  = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READY  = 3'd1,
    GREEN  = 3'd2,
    YELLOW = 3'd3,
    COMMIT = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t              state_q;
  logic [LETTER_W-1:0] target_q [WORD_LEN];
  logic [LETTER_W-1:0] guess_q  [WORD_LEN];
  logic [1:0]          mark_q   [WORD_LEN];
  logic                used_q   [WORD_LEN];
  logic [IDX_W-1:0]    i_idx;
  logic [IDX_W-1:0]    j_idx;

  logic [2*WORD_LEN-1:0] marks_c;
  logic                  all_green_c;
  logic [2:0]            guess_idx_inc_c;
  logic                  yellow_hit_c;

  // Pack per-letter marks into the result layout and detect a full match.
  always_comb begin
    marks_c     = '0;
    all_green_c = 1'b1;
    for (int k = 0; k < WORD_LEN; k++) begin
      marks_c[2*(WORD_LEN-1-k) +: 2] = mark_q[k];
      if (mark_q[k] != MARK_GREEN) begin
        all_green_c = 1'b0;
      end
    end
  end

  // Guess count after the commit in progress.
  always_comb begin
    guess_idx_inc_c = guess_idx + 3'd1;
  end

  // Current (i,j) pair of the yellow pass: guess letter i can claim target letter j.
  always_comb begin
    yellow_hit_c = (mark_q[i_idx] == MARK_GRAY) && !used_q[j_idx] &&
                   (guess_q[i_idx] == target_q[j_idx]);
  end

  // Game sequencer: state, scoring datapath and registered outputs.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      i_idx        <= '0;
      j_idx        <= '0;
      guess_ready  <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      guess_idx    <= '0;
      win          <= 1'b0;
      lose         <= 1'b0;
      game_over    <= 1'b0;
      for (int k = 0; k < WORD_LEN; k++) begin
        target_q[k] <= '0;
        guess_q[k]  <= '0;
        mark_q[k]   <= MARK_GRAY;
        used_q[k]   <= 1'b0;
      end
    end else begin
      result_valid <= 1'b0;
      if (start) begin
        // A new game aborts any scoring in flight; a simultaneous guess is dropped.
        for (int k = 0; k < WORD_LEN; k++) begin
          target_q[k] <= target_word[(WORD_LEN-1-k)*LETTER_W +: LETTER_W];
        end
        state_q     <= READY;
        i_idx       <= '0;
        j_idx       <= '0;
        guess_ready <= 1'b1;
        busy        <= 1'b0;
        result      <= '0;
        guess_idx   <= '0;
        win         <= 1'b0;
        lose        <= 1'b0;
        game_over   <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            state_q <= IDLE;
          end

          READY: begin
            if (guess_valid && guess_ready) begin
              for (int k = 0; k < WORD_LEN; k++) begin
                guess_q[k] <= guess_word[(WORD_LEN-1-k)*LETTER_W +: LETTER_W];
                mark_q[k]  <= MARK_GRAY;
                used_q[k]  <= 1'b0;
              end
              i_idx       <= '0;
              j_idx       <= '0;
              guess_ready <= 1'b0;
              busy        <= 1'b1;
              state_q     <= GREEN;
            end
          end

          GREEN: begin
            if (guess_q[i_idx] == target_q[i_idx]) begin
              mark_q[i_idx] <= MARK_GREEN;
              used_q[i_idx] <= 1'b1;
            end
            if (i_idx == LAST_IDX) begin
              i_idx   <= '0;
              j_idx   <= '0;
              state_q <= YELLOW;
            end else begin
              i_idx <= i_idx + IDX_W'(1);
            end
          end

          YELLOW: begin
            if (yellow_hit_c) begin
              mark_q[i_idx] <= MARK_YELLOW;
              used_q[j_idx] <= 1'b1;
            end
            if (j_idx == LAST_IDX) begin
              j_idx <= '0;
              if (i_idx == LAST_IDX) begin
                i_idx   <= '0;
                state_q <= COMMIT;
              end else begin
                i_idx <= i_idx + IDX_W'(1);
              end
            end else begin
              j_idx <= j_idx + IDX_W'(1);
            end
          end

          COMMIT: begin
            result       <= marks_c;
            result_valid <= 1'b1;
            guess_idx    <= guess_idx_inc_c;
            busy         <= 1'b0;
            if (all_green_c) begin
              win       <= 1'b1;
              game_over <= 1'b1;
              state_q   <= DONE;
            end else if (guess_idx_inc_c == GUESS_LIMIT) begin
              lose      <= 1'b1;
              game_over <= 1'b1;
              state_q   <= DONE;
            end else begin
              guess_ready <= 1'b1;
              state_q     <= READY;
            end
          end

          DONE: begin
            state_q <= DONE;
          end

          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wordle_score_ctrl.sv
`timescale 1ns/1ps
// Randomized bench for wordle_score_ctrl against a letter-count Wordle model.
module tb_wordle_score_ctrl;

  logic        Clk;
  logic        reset;
  logic        start;
  logic [39:0] target_word;
  logic        guess_valid;
  logic [39:0] guess_word;
  logic        guess_ready;
  logic        busy;
  logic        result_valid;
  logic [9:0]  result;
  logic [2:0]  guess_idx;
  logic        win;
  logic        lose;
  logic        game_over;

  int checks;
  int errors;

  logic [39:0] m_target;
  int          m_idx;
  bit          m_win;
  bit          m_lose;

  wordle_score_ctrl #(
    .LETTER_W    (8),
    .WORD_LEN    (5),
    .MAX_GUESSES (6)
  ) dut (
    .Clk          (Clk),
    .reset        (reset),
    .start        (start),
    .target_word  (target_word),
    .guess_valid  (guess_valid),
    .guess_word   (guess_word),
    .guess_ready  (guess_ready),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result),
    .guess_idx    (guess_idx),
    .win          (win),
    .lose         (lose),
    .game_over    (game_over)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Wordle scoring: greens first, then yellows drawn from a per-letter count of
  // target letters that were not matched exactly.
  function automatic logic [9:0] ref_score(input logic [39:0] t, input logic [39:0] g);
    int         cnt [256];
    logic [7:0] tl [5];
    logic [7:0] gl [5];
    logic [9:0] r;
    for (int c = 0; c < 256; c++) cnt[c] = 0;
    for (int k = 0; k < 5; k++) begin
      tl[k] = t[8*(4-k) +: 8];
      gl[k] = g[8*(4-k) +: 8];
    end
    r = '0;
    for (int k = 0; k < 5; k++) begin
      if (gl[k] == tl[k]) r[2*(4-k) +: 2] = 2'b10;
      else cnt[tl[k]]++;
    end
    for (int k = 0; k < 5; k++) begin
      if (gl[k] != tl[k] && cnt[gl[k]] > 0) begin
        r[2*(4-k) +: 2] = 2'b01;
        cnt[gl[k]]--;
      end
    end
    return r;
  endfunction

  function automatic logic [39:0] rand_word(input int alpha);
    logic [39:0] w;
    for (int k = 0; k < 5; k++) begin
      if ($urandom_range(0, 15) == 0) w[8*k +: 8] = 8'($urandom);
      else w[8*k +: 8] = 8'(65 + $urandom_range(0, alpha - 1));
    end
    return w;
  endfunction

  function automatic logic [39:0] junk();
    return {8'($urandom), 32'($urandom)};
  endfunction

  task automatic new_game(input logic [39:0] t);
    start       = 1'b1;
    target_word = t;
    @(posedge Clk); #1;
    start       = 1'b0;
    target_word = junk();
    m_target = t;
    m_idx    = 0;
    m_win    = 1'b0;
    m_lose   = 1'b0;
    chk("ng_ready", 32'(guess_ready), 32'd1);
    chk("ng_busy", 32'(busy), 32'd0);
    chk("ng_idx", 32'(guess_idx), 32'd0);
    chk("ng_result", 32'(result), 32'd0);
    chk("ng_status", 32'({win, lose, game_over}), 32'd0);
  endtask

  task automatic submit(input logic [39:0] w);
    logic [9:0] exp_r;
    int         n;
    bit         seen;
    chk("sub_ready", 32'(guess_ready), 32'd1);
    guess_valid = 1'b1;
    guess_word  = w;
    @(posedge Clk); #1;
    guess_valid = 1'b0;
    guess_word  = junk();
    chk("acc_busy", 32'(busy), 32'd1);
    chk("acc_ready", 32'(guess_ready), 32'd0);
    exp_r = ref_score(m_target, w);
    m_idx++;
    if (exp_r == 10'h2AA) m_win = 1'b1;
    else if (m_idx == 6) m_lose = 1'b1;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(posedge Clk); #1;
      n++;
      if (result_valid) seen = 1'b1;
      else if (n == 15) chk("mid_busy", 32'(busy), 32'd1);
    end
    chk("latency", 32'(n), 32'd31);
    chk("result", 32'(result), 32'(exp_r));
    chk("guess_idx", 32'(guess_idx), 32'(m_idx));
    chk("win", 32'(win), 32'(m_win));
    chk("lose", 32'(lose), 32'(m_lose));
    chk("game_over", 32'(game_over), 32'(m_win | m_lose));
    chk("ready_after", 32'(guess_ready), 32'(!(m_win || m_lose)));
    chk("busy_after", 32'(busy), 32'd0);
    @(posedge Clk); #1;
    chk("rv_pulse", 32'(result_valid), 32'd0);
    chk("result_hold", 32'(result), 32'(exp_r));
    chk("idx_hold", 32'(guess_idx), 32'(m_idx));
  endtask

  task automatic watch_quiet(input string tag, input int cycles);
    int cnt;
    cnt = 0;
    repeat (cycles) begin
      @(posedge Clk); #1;
      if (result_valid) cnt++;
    end
    chk(tag, 32'(cnt), 32'd0);
  endtask

  initial begin
    logic [39:0] w;
    checks      = 0;
    errors      = 0;
    reset       = 1'b0;
    start       = 1'b0;
    guess_valid = 1'b0;
    target_word = '0;
    guess_word  = '0;
    m_target    = '0;
    m_idx       = 0;
    m_win       = 1'b0;
    m_lose      = 1'b0;

    // Reset state and IDLE ignoring guesses.
    #3;
    chk("rst_outputs", 32'({guess_ready, busy, result_valid, result, guess_idx, win, lose, game_over}), 32'd0);
    repeat (2) @(posedge Clk);
    #1 reset = 1'b1;
    guess_valid = 1'b1;
    guess_word  = "CRANE";
    watch_quiet("idle_no_rv", 8);
    chk("idle_ready", 32'(guess_ready), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    guess_valid = 1'b0;

    // Directed scoring cases.
    new_game("CRANE");
    submit("CRANE");
    guess_valid = 1'b1;
    guess_word  = "CRANE";
    watch_quiet("done_no_rv", 40);
    chk("done_ready", 32'(guess_ready), 32'd0);
    guess_valid = 1'b0;

    new_game("ABBEY");
    submit("BABES");
    new_game("CRANE");
    submit("EERIE");

    // Six misses lose; a seventh guess is never accepted.
    new_game("CRANE");
    repeat (6) submit("ZZZZZ");
    guess_valid = 1'b1;
    guess_word  = "ZZZZZ";
    watch_quiet("lose_no_rv", 40);
    chk("lose_ready", 32'(guess_ready), 32'd0);
    chk("lose_idx", 32'(guess_idx), 32'd6);
    guess_valid = 1'b0;

    // Win on the sixth guess.
    new_game("CRANE");
    repeat (5) submit("ZZZZZ");
    submit("CRANE");

    // Abort 10 cycles into scoring.
    new_game("ABBEY");
    submit("BABES");
    guess_valid = 1'b1;
    guess_word  = "ABBEY";
    @(posedge Clk); #1;
    guess_valid = 1'b0;
    repeat (10) @(posedge Clk);
    #1;
    new_game("PLANT");
    watch_quiet("abort_no_rv", 40);
    submit("TAPAL");

    // start and guess_valid together: the guess is dropped.
    guess_valid = 1'b1;
    guess_word  = "LOOPS";
    new_game("LOOPS");
    guess_valid = 1'b0;
    watch_quiet("same_cycle_no_rv", 40);
    submit("POOLS");

    // Asynchronous reset mid-YELLOW.
    new_game("CRANE");
    submit("NACRE");
    guess_valid = 1'b1;
    guess_word  = "CRANE";
    @(posedge Clk); #1;
    guess_valid = 1'b0;
    repeat (10) @(posedge Clk);
    #1 reset = 1'b0;
    #1;
    chk("async_rst_outputs", 32'({guess_ready, busy, result_valid, result, guess_idx, win, lose, game_over}), 32'd0);
    @(posedge Clk);
    #2 reset = 1'b1;
    guess_valid = 1'b1;
    watch_quiet("post_rst_no_rv", 40);
    chk("post_rst_ready", 32'(guess_ready), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    guess_valid = 1'b0;

    // Randomized games over a small alphabet to stress duplicate letters.
    for (int g = 0; g < 25; g++) begin
      new_game(rand_word(4));
      while (!m_win && !m_lose) begin
        if ($urandom_range(0, 5) == 0) w = m_target;
        else w = rand_word(4);
        submit(w);
        repeat ($urandom_range(0, 3)) @(posedge Clk);
        #0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
